// File: rtl/rx_rst_sequencer.sv
// ============================================================================
// Module   : rx_rst_sequencer
// Turns watchdog/software reset requests into fixed-length rx resets plus a
// holdoff window. Optional cause capture: define RX_RST_SEQ_CAUSE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rx_rst_sequencer #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 enable,
   input  logic                 wd_rst,
   input  logic                 sw_rst,
   input  logic [7:0]           rst_len,
   input  logic [15:0]          holdoff_len,
   input  logic                 cnt_clr,
   output logic                 rx_rst,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] seq_cnt,
   output logic [1:0]           last_cause
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic        pending, pending_nxt;
   logic        wd_rst_d, sw_rst_d;
   logic        wd_trig, sw_trig, trig;
   logic        start;
   logic [15:0] assert_load;

   assign wd_trig = enable & wd_rst & ~wd_rst_d;
   assign sw_trig = sw_rst & ~sw_rst_d;
   assign trig    = wd_trig | sw_trig;

   // rst_len of zero behaves as a single-cycle reset
   assign assert_load = (rst_len == 8'd0) ? 16'd0 : {8'd0, rst_len - 8'd1};

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pending_nxt = pending;
      start       = 1'b0;
      case (state)
         IDLE: begin
            if (trig) begin
               state_nxt = ASSERT;
               cnt_nxt   = assert_load;
               start     = 1'b1;
            end
         end
         ASSERT: begin
            if (cnt == 16'd0) begin
               if (holdoff_len == 16'd0) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = HOLDOFF;
                  cnt_nxt   = holdoff_len - 16'd1;
               end
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         HOLDOFF: begin
            if (cnt == 16'd0) begin
               pending_nxt = 1'b0;
               if (pending || trig) begin
                  state_nxt = ASSERT;
                  cnt_nxt   = assert_load;
                  start     = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt - 16'd1;
               if (trig) pending_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            pending_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cnt      <= 16'd0;
         pending  <= 1'b0;
         wd_rst_d <= 1'b0;
         sw_rst_d <= 1'b0;
         rx_rst   <= 1'b0;
         busy     <= 1'b0;
         seq_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pending  <= pending_nxt;
         wd_rst_d <= wd_rst;
         sw_rst_d <= sw_rst;
         rx_rst   <= (state_nxt == ASSERT);
         busy     <= (state_nxt != IDLE);
         if (cnt_clr)
            seq_cnt <= '0;
         else if (start && !(&seq_cnt))
            seq_cnt <= seq_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

`ifdef RX_RST_SEQ_CAUSE_EN
   logic [1:0] pend_cause;
   logic [1:0] trig_cause;

   assign trig_cause = {sw_trig, wd_trig};

   // Causes seen during holdoff are folded into the back-to-back entry
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_cause <= 2'b00;
         pend_cause <= 2'b00;
      end else begin
         if (start) begin
            last_cause <= pend_cause | trig_cause;
            pend_cause <= 2'b00;
         end else if (state_nxt == IDLE) begin
            pend_cause <= 2'b00;
         end else if (state == HOLDOFF && trig) begin
            pend_cause <= pend_cause | trig_cause;
         end
      end
   end
`else
   assign last_cause = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_rst_sequencer.sv
// ============================================================================
// Module   : tb_rx_rst_sequencer
// Directed stimulus with an event scoreboard for rx_rst_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rx_rst_sequencer;

   localparam int EV_RISE = 0;
   localparam int EV_FALL = 1;
   localparam int EV_END  = 2;

   typedef struct {
      int         kind;
      int         cyc;
      int         cnt;
      logic [1:0] cause;
   } ev_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enable;
   logic        wd_rst;
   logic        sw_rst;
   logic [7:0]  rst_len;
   logic [15:0] holdoff_len;
   logic        cnt_clr;
   logic        rx_rst;
   logic        busy;
   logic [3:0]  seq_cnt;
   logic [1:0]  last_cause;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   t0;
   int   n;
   ev_t  exp_q[$];
   logic prev_rx   = 1'b0;
   logic prev_busy = 1'b0;

   rx_rst_sequencer #(.CNT_WIDTH(4)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .enable      (enable),
      .wd_rst      (wd_rst),
      .sw_rst      (sw_rst),
      .rst_len     (rst_len),
      .holdoff_len (holdoff_len),
      .cnt_clr     (cnt_clr),
      .rx_rst      (rx_rst),
      .busy        (busy),
      .seq_cnt     (seq_cnt),
      .last_cause  (last_cause)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int kind, input int c, input int cnt, input logic [1:0] cause);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.cnt  = cnt;
`ifdef RX_RST_SEQ_CAUSE_EN
      e.cause = cause;
`else
      e.cause = 2'b00;
`endif
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic go(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_ev(input int kind);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event kind=%0d cyc=%0d", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc) begin
            failures++;
            $display("FAIL event_timing actual kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                     kind, cyc, e.kind, e.cyc);
         end
         checks++;
         if (int'(seq_cnt) != e.cnt) begin
            failures++;
            $display("FAIL event_seq_cnt cyc=%0d actual=%0d expected=%0d", cyc, seq_cnt, e.cnt);
         end
         if (kind == EV_RISE) begin
            checks++;
            if (last_cause !== e.cause) begin
               failures++;
               $display("FAIL event_cause cyc=%0d actual=%b expected=%b", cyc, last_cause, e.cause);
            end
         end
      end
   endtask

   // Monitor: every rx_rst edge and busy fall must match the next expected event
   always @(negedge clk) begin
      if (rx_rst && !prev_rx)   check_ev(EV_RISE);
      if (!rx_rst && prev_rx)   check_ev(EV_FALL);
      if (!busy && prev_busy)   check_ev(EV_END);
      prev_rx   = rx_rst;
      prev_busy = busy;
   end

   initial begin
      rstn = 1'b0; enable = 1'b0; wd_rst = 1'b0; sw_rst = 1'b0;
      rst_len = 8'd4; holdoff_len = 16'd10; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rx_rst", rx_rst, 0);
      chk("reset_busy", busy, 0);
      chk("reset_seq_cnt", seq_cnt, 0);
      chk("reset_last_cause", last_cause, 0);
      rstn = 1'b1;
      go(cyc + 2);

      // Long wd level: single 4-cycle reset, 10-cycle holdoff
      enable = 1'b1;
      go(cyc + 1); t0 = cyc;
      push(EV_RISE, t0 + 1, 1, 2'b01);
      push(EV_FALL, t0 + 5, 1, 2'b00);
      push(EV_END,  t0 + 15, 1, 2'b00);
      wd_rst = 1'b1;
      go(t0 + 50); wd_rst = 1'b0;
      go(t0 + 52);
      chk("t1_seq_cnt", seq_cnt, 1);

      // Edge during ASSERT merged; edge during HOLDOFF re-enters back-to-back
      go(cyc + 1); t0 = cyc;
      push(EV_RISE, t0 + 1, 2, 2'b01);
      push(EV_FALL, t0 + 5, 2, 2'b00);
      push(EV_RISE, t0 + 15, 3, 2'b01);
      push(EV_FALL, t0 + 19, 3, 2'b00);
      push(EV_END,  t0 + 29, 3, 2'b00);
      wd_rst = 1'b1;
      go(t0 + 2); wd_rst = 1'b0;
      go(t0 + 3); wd_rst = 1'b1;
      go(t0 + 6); wd_rst = 1'b0;
      go(t0 + 8); wd_rst = 1'b1;
      go(t0 + 30); wd_rst = 1'b0;
      go(t0 + 32);

      // enable=0 blocks wd; sw accepted, incl. on the final holdoff cycle
      enable = 1'b0;
      go(cyc + 1); t0 = cyc;
      push(EV_RISE, t0 + 4, 4, 2'b10);
      push(EV_FALL, t0 + 8, 4, 2'b00);
      push(EV_RISE, t0 + 18, 5, 2'b10);
      push(EV_FALL, t0 + 22, 5, 2'b00);
      push(EV_END,  t0 + 32, 5, 2'b00);
      wd_rst = 1'b1;
      go(t0 + 1);  wd_rst = 1'b0;
      go(t0 + 3);  sw_rst = 1'b1;
      go(t0 + 4);  sw_rst = 1'b0;
      go(t0 + 10); wd_rst = 1'b1;
      go(t0 + 11); wd_rst = 1'b0;
      go(t0 + 17); sw_rst = 1'b1;
      go(t0 + 18); sw_rst = 1'b0;
      go(t0 + 34);
      enable = 1'b1;

      // Zero lengths: one-cycle reset and busy
      rst_len = 8'd0; holdoff_len = 16'd0;
      go(cyc + 1); t0 = cyc;
      push(EV_RISE, t0 + 1, 6, 2'b10);
      push(EV_FALL, t0 + 2, 6, 2'b00);
      push(EV_END,  t0 + 2, 6, 2'b00);
      sw_rst = 1'b1;
      go(t0 + 1); sw_rst = 1'b0;
      go(t0 + 4);

      // Async reset in the middle of ASSERT
      rst_len = 8'd8; holdoff_len = 16'd5;
      go(cyc + 1); t0 = cyc;
      push(EV_RISE, t0 + 1, 7, 2'b01);
      wd_rst = 1'b1;
      go(t0 + 3);
      push(EV_FALL, t0 + 3, 0, 2'b00);
      push(EV_END,  t0 + 3, 0, 2'b00);
      rstn = 1'b0;
      #1;
      chk("async_rx_rst", rx_rst, 0);
      chk("async_busy", busy, 0);
      chk("async_seq_cnt", seq_cnt, 0);
      chk("async_last_cause", last_cause, 0);
      wd_rst = 1'b0;
      go(t0 + 5); rstn = 1'b1;
      go(t0 + 7);
      rst_len = 8'd2; holdoff_len = 16'd3;
      go(cyc + 1); t0 = cyc;
      push(EV_RISE, t0 + 1, 1, 2'b10);
      push(EV_FALL, t0 + 3, 1, 2'b00);
      push(EV_END,  t0 + 6, 1, 2'b00);
      sw_rst = 1'b1;
      go(t0 + 1); sw_rst = 1'b0;
      go(t0 + 8);

      // Saturation of the 4-bit counter, then clear beating an increment
      rst_len = 8'd0; holdoff_len = 16'd0;
      n = 1;
      go(cyc + 1);
      for (int i = 0; i < 16; i++) begin
         t0 = cyc;
         n  = (n < 15) ? n + 1 : 15;
         push(EV_RISE, t0 + 1, n, 2'b10);
         push(EV_FALL, t0 + 2, n, 2'b00);
         push(EV_END,  t0 + 2, n, 2'b00);
         sw_rst = 1'b1;
         go(t0 + 1); sw_rst = 1'b0;
         go(t0 + 2);
      end
      chk("sat_seq_cnt", seq_cnt, 15);
      go(cyc + 1); t0 = cyc;
      push(EV_RISE, t0 + 1, 0, 2'b10);
      push(EV_FALL, t0 + 2, 0, 2'b00);
      push(EV_END,  t0 + 2, 0, 2'b00);
      sw_rst = 1'b1; cnt_clr = 1'b1;
      go(t0 + 1); sw_rst = 1'b0; cnt_clr = 1'b0;
      go(t0 + 4);
      chk("clr_seq_cnt", seq_cnt, 0);

      go(cyc + 3);
      chk("events_outstanding", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
